// File: rtl/cdb_arbiter_if.sv
// Result-producer and CDB bundle for cdb_arbiter: ALU/LSB results in, full flags and broadcast out.
// No CDB back-pressure; producers must hold off while their full flag is set.
interface cdb_arbiter_if #(
    parameter int ROB_BIT = 4
) ();
    logic               alu_valid;
    logic [ROB_BIT-1:0] alu_rob_entry;
    logic [31:0]        alu_value;
    logic               alu_full;
    logic               lsb_valid;
    logic [ROB_BIT-1:0] lsb_rob_entry;
    logic [31:0]        lsb_value;
    logic               lsb_full;
    logic               cdb_valid;
    logic [ROB_BIT-1:0] cdb_rob_entry;
    logic [31:0]        cdb_value;

    modport master (
        output alu_valid, alu_rob_entry, alu_value,
        output lsb_valid, lsb_rob_entry, lsb_value,
        input  alu_full, lsb_full,
        input  cdb_valid, cdb_rob_entry, cdb_value
    );

    modport slave (
        input  alu_valid, alu_rob_entry, alu_value,
        input  lsb_valid, lsb_rob_entry, lsb_value,
        output alu_full, lsb_full,
        output cdb_valid, cdb_rob_entry, cdb_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB scheduler over per-source ALU/LSB FIFOs; 2-edge latency (1 edge with CDB_BYPASS_EN).
// Back-pressure only via alu_full/lsb_full; the registered broadcast is a one-cycle pulse.
module cdb_arbiter #(
    parameter int ROB_BIT    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_BIT   = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          rob_clear_up,
    cdb_arbiter_if.slave  bus
);
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSB = 1'b1;
    localparam int   EW        = ROB_BIT + 32;
    localparam int   CW        = FIFO_BIT + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [EW-1:0]       alu_mem [FIFO_DEPTH];
    logic [EW-1:0]       lsb_mem [FIFO_DEPTH];
    logic [FIFO_BIT-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
    logic [CW-1:0]       alu_cnt, lsb_cnt;
    logic                last_grant;

    logic          alu_ne, lsb_ne, grant_alu, grant_lsb;
    logic          alu_acc, lsb_acc, byp_alu, byp_lsb;
    logic          alu_push, lsb_push, cdb_load;
    logic [EW-1:0] cdb_dat;

    assign bus.alu_full = (alu_cnt == FULL_CNT);
    assign bus.lsb_full = (lsb_cnt == FULL_CNT);

    always_comb begin
        alu_ne    = (alu_cnt != '0);
        lsb_ne    = (lsb_cnt != '0);
        grant_alu = alu_ne && (!lsb_ne || last_grant == GRANT_LSB);
        grant_lsb = lsb_ne && (!alu_ne || last_grant == GRANT_ALU);
        alu_acc   = bus.alu_valid && !bus.alu_full;
        lsb_acc   = bus.lsb_valid && !bus.lsb_full;
`ifdef CDB_BYPASS_EN
        // With both FIFOs empty, the round-robin winner among live inputs skips its FIFO.
        byp_alu = !alu_ne && !lsb_ne && alu_acc && (!lsb_acc || last_grant == GRANT_LSB);
        byp_lsb = !alu_ne && !lsb_ne && lsb_acc && (!alu_acc || last_grant == GRANT_ALU);
`else
        byp_alu = 1'b0;
        byp_lsb = 1'b0;
`endif
        alu_push = alu_acc && !byp_alu;
        lsb_push = lsb_acc && !byp_lsb;
        cdb_load = grant_alu || grant_lsb || byp_alu || byp_lsb;
        if (grant_alu)
            cdb_dat = alu_mem[alu_head];
        else if (grant_lsb)
            cdb_dat = lsb_mem[lsb_head];
        else if (byp_alu)
            cdb_dat = {bus.alu_rob_entry, bus.alu_value};
        else
            cdb_dat = {bus.lsb_rob_entry, bus.lsb_value};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && !rob_clear_up && rdy_in) begin
            if (alu_push)
                alu_mem[alu_tail] <= {bus.alu_rob_entry, bus.alu_value};
            if (lsb_push)
                lsb_mem[lsb_tail] <= {bus.lsb_rob_entry, bus.lsb_value};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_head          <= '0;
            alu_tail          <= '0;
            alu_cnt           <= '0;
            lsb_head          <= '0;
            lsb_tail          <= '0;
            lsb_cnt           <= '0;
            last_grant        <= GRANT_LSB;
            bus.cdb_valid     <= 1'b0;
            bus.cdb_rob_entry <= '0;
            bus.cdb_value     <= '0;
        end else if (rob_clear_up) begin
            // Flush drops queued results; the last broadcast payload and arbitration history stay.
            alu_head      <= '0;
            alu_tail      <= '0;
            alu_cnt       <= '0;
            lsb_head      <= '0;
            lsb_tail      <= '0;
            lsb_cnt       <= '0;
            bus.cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            if (alu_push)
                alu_tail <= alu_tail + FIFO_BIT'(1);
            if (grant_alu)
                alu_head <= alu_head + FIFO_BIT'(1);
            if (lsb_push)
                lsb_tail <= lsb_tail + FIFO_BIT'(1);
            if (grant_lsb)
                lsb_head <= lsb_head + FIFO_BIT'(1);
            alu_cnt       <= alu_cnt + CW'(alu_push) - CW'(grant_alu);
            lsb_cnt       <= lsb_cnt + CW'(lsb_push) - CW'(grant_lsb);
            bus.cdb_valid <= cdb_load;
            if (cdb_load) begin
                {bus.cdb_rob_entry, bus.cdb_value} <= cdb_dat;
                last_grant <= (grant_alu || byp_alu) ? GRANT_ALU : GRANT_LSB;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: per-source expected queues plus broadcast-order log.
module tb_cdb_arbiter;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, rob_clear_up;
    int   checks = 0;
    int   errors = 0;

    logic [35:0] alu_q[$];
    logic [35:0] lsb_q[$];
    int          log_q[$];

    cdb_arbiter_if #(.ROB_BIT(4)) bus ();

    cdb_arbiter #(.ROB_BIT(4), .FIFO_DEPTH(4), .FIFO_BIT(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid     = 1'b0;
        bus.alu_rob_entry = '0;
        bus.alu_value     = '0;
        bus.lsb_valid     = 1'b0;
        bus.lsb_rob_entry = '0;
        bus.lsb_value     = '0;
    endtask

    task automatic drive_alu(input logic [3:0] e, input logic [31:0] v, input bit expect_acc);
        bus.alu_valid     = 1'b1;
        bus.alu_rob_entry = e;
        bus.alu_value     = v;
        if (expect_acc) alu_q.push_back({e, v});
    endtask

    task automatic drive_lsb(input logic [3:0] e, input logic [31:0] v, input bit expect_acc);
        bus.lsb_valid     = 1'b1;
        bus.lsb_rob_entry = e;
        bus.lsb_value     = v;
        if (expect_acc) lsb_q.push_back({e, v});
    endtask

    // One clock; inputs are stable across the posedge and outputs are sampled at the negedge.
    task automatic tick();
        logic [35:0] exp;
        @(posedge clk_in);
        @(negedge clk_in);
        if (rdy_in && bus.cdb_valid === 1'b1) begin
            log_q.push_back(int'(bus.cdb_rob_entry));
            if (bus.cdb_value[31:28] == 4'hA) begin
                check("alu_pending", 32'(alu_q.size() > 0), 32'd1);
                if (alu_q.size() > 0) begin
                    exp = alu_q.pop_front();
                    check("alu_entry", 32'(bus.cdb_rob_entry), 32'(exp[35:32]));
                    check("alu_value", bus.cdb_value, exp[31:0]);
                end
            end else if (bus.cdb_value[31:28] == 4'hB) begin
                check("lsb_pending", 32'(lsb_q.size() > 0), 32'd1);
                if (lsb_q.size() > 0) begin
                    exp = lsb_q.pop_front();
                    check("lsb_entry", 32'(bus.cdb_rob_entry), 32'(exp[35:32]));
                    check("lsb_value", bus.cdb_value, exp[31:0]);
                end
            end else begin
                check("cdb_source_tag", 32'(bus.cdb_value[31:28]), 32'hA);
            end
        end
    endtask

    task automatic do_reset();
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        rob_clear_up = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_in = 1'b0;
        alu_q.delete();
        lsb_q.delete();
        log_q.delete();
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        foreach (exp[i])
            check(tag, (log_q.size() > i) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    initial begin
        int seq2[$];
        int seq3[$];
        int seq6[$];
        seq2 = '{1, 2};
        seq3 = '{4, 8, 5, 9, 6, 10, 7, 11};
        seq6 = '{1, 2, 3};

        // Reset state
        do_reset();
        check("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("rst_cdb_entry", 32'(bus.cdb_rob_entry), 32'd0);
        check("rst_cdb_value", bus.cdb_value, 32'd0);
        check("rst_alu_full", 32'(bus.alu_full), 32'd0);
        check("rst_lsb_full", 32'(bus.lsb_full), 32'd0);

        // Single ALU result: two-edge latency, one-cycle pulse
        drive_alu(4'd3, 32'hA000_0011, 1'b1);
        tick();
        idle_inputs();
        check("t1_edge1_valid", 32'(bus.cdb_valid), 32'd0);
        check("t1_alu_full", 32'(bus.alu_full), 32'd0);
        tick();
        check("t1_edge2_valid", 32'(bus.cdb_valid), 32'd1);
        check("t1_edge2_entry", 32'(bus.cdb_rob_entry), 32'd3);
        check("t1_edge2_value", bus.cdb_value, 32'hA000_0011);
        tick();
        check("t1_edge3_valid", 32'(bus.cdb_valid), 32'd0);
        check("t1_alu_full_end", 32'(bus.alu_full), 32'd0);

        // Simultaneous ALU and LSB after reset: ALU wins the first tie
        do_reset();
        drive_alu(4'd1, 32'hA000_000A, 1'b1);
        drive_lsb(4'd2, 32'hB000_000B, 1'b1);
        tick();
        idle_inputs();
        repeat (4) tick();
        check_seq("t2_order", seq2);

        // Concurrent bursts alternate under contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_alu(4'(4 + i), 32'hA000_0000 | 32'(4 + i), 1'b1);
            drive_lsb(4'(8 + i), 32'hB000_0000 | 32'(8 + i), 1'b1);
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        check_seq("t3_order", seq3);

        // LSB outpaces its alternating pops until full; a push while full is dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_alu(4'(i), 32'hA000_0000 | 32'(i), 1'b1);
            drive_lsb(4'(i), 32'hB000_0000 | 32'(i), 1'b1);
            tick();
            check("t4_lsb_full", 32'(bus.lsb_full), (i == 5) ? 32'd1 : 32'd0);
            check("t4_alu_full", 32'(bus.alu_full), 32'd0);
        end
        idle_inputs();
        drive_lsb(4'd15, 32'hB000_00FF, 1'b0);
        tick();
        idle_inputs();
        check("t4_lsb_full_after_pop", 32'(bus.lsb_full), 32'd0);
        check("t4_popped_lsb_entry", 32'(bus.cdb_rob_entry), 32'd2);
        repeat (10) tick();
        check("t4_alu_drained", 32'(alu_q.size()), 32'd0);
        check("t4_lsb_drained", 32'(lsb_q.size()), 32'd0);

        // Flush with three entries queued per source
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alu(4'(i), 32'hA000_0000 | 32'(i), 1'b1);
            drive_lsb(4'(i), 32'hB000_0000 | 32'(i), 1'b1);
            tick();
        end
        rob_clear_up = 1'b1;
        drive_alu(4'd9, 32'hA000_0009, 1'b0);
        drive_lsb(4'd9, 32'hB000_0009, 1'b0);
        tick();
        rob_clear_up = 1'b0;
        idle_inputs();
        alu_q.delete();
        lsb_q.delete();
        check("t5_flush_valid", 32'(bus.cdb_valid), 32'd0);
        check("t5_flush_alu_full", 32'(bus.alu_full), 32'd0);
        check("t5_flush_lsb_full", 32'(bus.lsb_full), 32'd0);
        check("t5_hold_entry", 32'(bus.cdb_rob_entry), 32'd1);
        check("t5_hold_value", bus.cdb_value, 32'hB000_0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_stale", 32'(bus.cdb_valid), 32'd0);
        end

        // Stall with two entries pending
        do_reset();
        drive_alu(4'd1, 32'hA000_0001, 1'b1);
        drive_lsb(4'd2, 32'hB000_0002, 1'b1);
        tick();
        idle_inputs();
        drive_alu(4'd3, 32'hA000_0003, 1'b1);
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_frozen_valid", 32'(bus.cdb_valid), 32'd1);
            check("t6_frozen_entry", 32'(bus.cdb_rob_entry), 32'd1);
            check("t6_frozen_value", bus.cdb_value, 32'hA000_0001);
        end
        rdy_in = 1'b1;
        tick();
        check("t6_drain1_entry", 32'(bus.cdb_rob_entry), 32'd2);
        tick();
        check("t6_drain2_entry", 32'(bus.cdb_rob_entry), 32'd3);
        tick();
        check("t6_drain_done", 32'(bus.cdb_valid), 32'd0);
        check_seq("t6_order", seq6);

        check("final_alu_empty", 32'(alu_q.size()), 32'd0);
        check("final_lsb_empty", 32'(lsb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
